// File: rtl/scan_result_reader_if.sv
// Handshake bundle for scan_result_reader: start/ready control, BRAM read port and beat stream.
interface scan_result_reader_if #(
    parameter int NUM_CHAINS = 4,
    parameter int ADDR_W     = 10,
    parameter int OUT_WIDTH  = 32
);
    logic                  start;
    logic                  ready;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [NUM_CHAINS-1:0] rd_data;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        input  start, rd_data, out_ready,
        output ready, rd_en, rd_addr, out_data, out_valid, out_last
    );

    modport slave (
        output start, rd_data, out_ready,
        input  ready, rd_en, rd_addr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/scan_result_reader.sv
// Drains the scan-result BRAM in address order and streams packed OUT_WIDTH-bit beats.
// Optional feature macro SPIN_COUNT_EN adds per-chain ones counters on spin_count.
module scan_result_reader #(
    parameter int NUM_CHAINS          = 4,
    parameter int NUM_CHIPS_PER_CHAIN = 2,
    parameter int OUT_WIDTH           = 32,
    // Non-zero forces the drain depth (small builds for partial-beat coverage).
    parameter int DEPTH_OVERRIDE      = 0,
    localparam int SCAN_CHAIN_DEPTH   = (DEPTH_OVERRIDE != 0) ? DEPTH_OVERRIDE
                                                              : 504 * NUM_CHIPS_PER_CHAIN
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SPIN_COUNT_EN
    output logic [NUM_CHAINS*$clog2(SCAN_CHAIN_DEPTH+1)-1:0] spin_count,
`endif
    scan_result_reader_if.master bus
);
    localparam int APB    = OUT_WIDTH / NUM_CHAINS;
    localparam int ADDR_W = $clog2(SCAN_CHAIN_DEPTH);
    localparam int CNT_W  = $clog2(APB + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCAN_CHAIN_DEPTH - 1);
    localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(APB - 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_OUT, S_DONE} state_t;

    state_t               state_r, state_nx;
    logic                 ready_r, ready_nx;
    logic                 rd_en_r, rd_en_nx;
    logic [ADDR_W-1:0]    rd_addr_r, rd_addr_nx;
    logic [CNT_W-1:0]     rd_cnt_r, rd_cnt_nx;
    logic                 out_valid_r, out_valid_nx;
    logic                 out_last_r, out_last_nx;
    logic                 clr_pack_s;
    logic                 start_acc_s;
    logic                 cap_en_r;
    logic [CNT_W-1:0]     cap_lane_r;
    logic [OUT_WIDTH-1:0] pack_r;

    // Next-state and next-output decode; rd_addr holds the last issued address between beats.
    always_comb begin
        state_nx     = state_r;
        rd_en_nx     = 1'b0;
        rd_addr_nx   = rd_addr_r;
        rd_cnt_nx    = rd_cnt_r;
        out_valid_nx = 1'b0;
        out_last_nx  = 1'b0;
        clr_pack_s   = 1'b0;
        start_acc_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx    = S_READ;
                    rd_en_nx    = 1'b1;
                    rd_addr_nx  = {ADDR_W{1'b0}};
                    rd_cnt_nx   = {CNT_W{1'b0}};
                    clr_pack_s  = 1'b1;
                    start_acc_s = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_READ: begin
                if ((rd_addr_r == LAST_ADDR) || (rd_cnt_r == LAST_LANE)) begin
                    state_nx = S_WAIT;
                end else begin
                    rd_en_nx   = 1'b1;
                    rd_addr_nx = rd_addr_r + ADDR_W'(1);
                    rd_cnt_nx  = rd_cnt_r + CNT_W'(1);
                end
            end
            S_WAIT: begin
                state_nx     = S_OUT;
                out_valid_nx = 1'b1;
                out_last_nx  = (rd_addr_r == LAST_ADDR);
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    if (out_last_r) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx   = S_READ;
                        rd_en_nx   = 1'b1;
                        rd_addr_nx = rd_addr_r + ADDR_W'(1);
                        rd_cnt_nx  = {CNT_W{1'b0}};
                        clr_pack_s = 1'b1;
                    end
                end else begin
                    out_valid_nx = 1'b1;
                    out_last_nx  = out_last_r;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        ready_nx = (state_nx == S_IDLE);
    end

    // State and registered control outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            ready_r     <= 1'b1;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= {ADDR_W{1'b0}};
            rd_cnt_r    <= {CNT_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            state_r     <= state_nx;
            ready_r     <= ready_nx;
            rd_en_r     <= rd_en_nx;
            rd_addr_r   <= rd_addr_nx;
            rd_cnt_r    <= rd_cnt_nx;
            out_valid_r <= out_valid_nx;
            out_last_r  <= out_last_nx;
        end
    end

    // Capture returned words one cycle after their read into lane (addr mod APB).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_en_r   <= 1'b0;
            cap_lane_r <= {CNT_W{1'b0}};
            pack_r     <= {OUT_WIDTH{1'b0}};
        end else begin
            cap_en_r   <= rd_en_r;
            cap_lane_r <= rd_cnt_r;
            if (clr_pack_s) begin
                pack_r <= {OUT_WIDTH{1'b0}};
            end else if (cap_en_r) begin
                for (int i = 0; i < APB; i++) begin
                    if (cap_lane_r == CNT_W'(i)) begin
                        pack_r[i*NUM_CHAINS +: NUM_CHAINS] <= bus.rd_data;
                    end
                end
            end
        end
    end

    assign bus.ready     = ready_r;
    assign bus.rd_en     = rd_en_r;
    assign bus.rd_addr   = rd_addr_r;
    assign bus.out_data  = pack_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;

`ifdef SPIN_COUNT_EN
    localparam int SPIN_W = $clog2(SCAN_CHAIN_DEPTH + 1);
    logic [NUM_CHAINS*SPIN_W-1:0] spin_r;

    // Per-chain ones count, accumulated on the same capture strobe as the pack register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spin_r <= {(NUM_CHAINS*SPIN_W){1'b0}};
        end else if (start_acc_s) begin
            spin_r <= {(NUM_CHAINS*SPIN_W){1'b0}};
        end else if (cap_en_r) begin
            for (int c = 0; c < NUM_CHAINS; c++) begin
                spin_r[c*SPIN_W +: SPIN_W] <= spin_r[c*SPIN_W +: SPIN_W] + SPIN_W'(bus.rd_data[c]);
            end
        end
    end

    assign spin_count = spin_r;
`endif
endmodule
